rf_alu_datapath: RTL



---
 rtl/rf_alu_datapath.sv | 98 +++++++++
 1 files changed

// File: rtl/rf_alu_datapath.sv
// Register file + ALU datapath that executes one control word per clk cycle.
// Latency: reads/ALU/aBTb combinational; register write and outPort load one cycle.
// Backpressure: none; every control word is consumed in the cycle it is presented.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   RFSrcMuxSel                    write data select: 0 = ALU result, 1 = constant 1
//   readAddr1/readAddr2/writeAddr  register file addresses (R0 reads as zero)
//   writeEn, outBuf                register write enable, output buffer load enable
//   aluOP                          ALU operation select
//   aBTb                           RData1 > RData2 (unsigned), combinational
//   outPort, outValid              registered output buffer and its one-cycle valid pulse
module rf_alu_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int RF_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RFSrcMuxSel,
    input  logic [2:0]            readAddr1,
    input  logic [2:0]            readAddr2,
    input  logic [2:0]            writeAddr,
    input  logic                  writeEn,
    input  logic                  outBuf,
    input  logic [2:0]            aluOP,
    output logic                  aBTb,
    output logic [DATA_WIDTH-1:0] outPort,
    output logic                  outValid
);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOT  = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_t;

    logic [DATA_WIDTH-1:0] regs [RF_DEPTH];
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] wdata;
    alu_op_t               op;

    // R0 is forced to zero on the read side, so its storage is never written.
    assign rdata1 = (readAddr1 == 3'd0) ? '0 : regs[readAddr1];
    assign rdata2 = (readAddr2 == 3'd0) ? '0 : regs[readAddr2];

    assign aBTb = (rdata1 > rdata2);

    assign op = alu_op_t'(aluOP);

    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD:  alu_result = rdata1 + rdata2;
            ALU_SUB:  alu_result = rdata1 - rdata2;
            ALU_AND:  alu_result = rdata1 & rdata2;
            ALU_OR:   alu_result = rdata1 | rdata2;
            ALU_XOR:  alu_result = rdata1 ^ rdata2;
            ALU_NOT:  alu_result = ~rdata1;
            ALU_SHL:  alu_result = {rdata1[DATA_WIDTH-2:0], 1'b0};
            ALU_PASS: alu_result = rdata1;
            default:  alu_result = '0;
        endcase
    end

    assign wdata = RFSrcMuxSel ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : alu_result;

    // No write bypass: a same-cycle read of writeAddr sees the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn && (writeAddr != 3'd0)) begin
            regs[writeAddr] <= wdata;
        end
    end

    // outPort captures pre-write RData1 because rdata1 is sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            outPort  <= '0;
            outValid <= 1'b0;
        end else begin
            outValid <= outBuf;
            if (outBuf) begin
                outPort <= rdata1;
            end
        end
    end

endmodule
